// File: rtl/cpa_pipe.sv
// Pipelined carry-propagate adder: resolves the final sum/carry rows of the
// compressor tree CHUNK bits per stage, with operands skewed down the pipe.
module cpa_pipe #(
    parameter int    WIDTH  = 32,
    parameter int    CHUNK  = 8,
    parameter string OUTREG = "TRUE"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);
    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

    logic             en;
    logic [WIDTH-1:0] last_r;
    logic             last_c;
    logic             last_v;

    // One global enable: the whole pipe freezes while the output is stalled.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int W  = (k == STAGES - 1) ? WIDTH - LO : CHUNK;
        localparam int BI = WIDTH - LO;

        // r carries finished sum bits below LO and untouched a bits above;
        // b only keeps the bits not yet consumed, so it shrinks each stage.
        logic [WIDTH-1:0] r_in;
        logic [WIDTH-1:0] r_d;
        logic [WIDTH-1:0] r_q;
        logic [BI-1:0]    b_in;
        logic             c_in;
        logic             v_in;
        logic             c_q;
        logic             v_q;
        logic [W:0]       add;

        if (k == 0) begin : g_src
            assign r_in = in_a;
            assign b_in = in_b;
            assign c_in = in_cin;
            assign v_in = in_valid;
        end else begin : g_src
            assign r_in = g_stage[k-1].r_q;
            assign b_in = g_stage[k-1].g_b.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
        end

        always_comb begin
            add           = {1'b0, r_in[LO +: W]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};
            r_d           = r_in;
            r_d[LO +: W]  = add[W-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                r_q <= r_d;
                c_q <= add[W];
                v_q <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_b
            logic [BI-W-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    b_q <= '0;
                end else if (en) begin
                    b_q <= b_in[BI-1:W];
                end
            end
        end
    end

    assign last_r = g_stage[STAGES-1].r_q;
    assign last_c = g_stage[STAGES-1].c_q;
    assign last_v = g_stage[STAGES-1].v_q;

    if (OUTREG == "TRUE") begin : g_out
        logic [WIDTH-1:0] sum_q;
        logic             cout_q;
        logic             vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q  <= '0;
                cout_q <= 1'b0;
                vld_q  <= 1'b0;
            end else if (en) begin
                sum_q  <= last_r;
                cout_q <= last_c;
                vld_q  <= last_v;
            end
        end

        assign out_sum   = sum_q;
        assign out_cout  = cout_q;
        assign out_valid = vld_q;
    end else begin : g_out
        assign out_sum   = last_r;
        assign out_cout  = last_c;
        assign out_valid = last_v;
    end

endmodule

// File: tb/tb_cpa_pipe.sv
// Directed bench for cpa_pipe: three configurations (32/8 registered,
// 12/8 unregistered, 32/32 registered) checked against hand sums.
module tb_cpa_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Config A: WIDTH=32, CHUNK=8, OUTREG=TRUE
    logic        rstA, ivA, irA, cinA, ovA, orA, coA;
    logic [31:0] aA, bA, sA;
    // Config B: WIDTH=12, CHUNK=8, OUTREG=FALSE
    logic        rstB, ivB, irB, cinB, ovB, orB, coB;
    logic [11:0] aB, bB, sB;
    // Config C: WIDTH=32, CHUNK=32, OUTREG=TRUE
    logic        rstC, ivC, irC, cinC, ovC, orC, coC;
    logic [31:0] aC, bC, sC;

    cpa_pipe #(.WIDTH(32), .CHUNK(8), .OUTREG("TRUE")) uA (
        .clk(clk), .rst(rstA), .in_valid(ivA), .in_ready(irA), .in_a(aA), .in_b(bA),
        .in_cin(cinA), .out_valid(ovA), .out_ready(orA), .out_sum(sA), .out_cout(coA));
    cpa_pipe #(.WIDTH(12), .CHUNK(8), .OUTREG("FALSE")) uB (
        .clk(clk), .rst(rstB), .in_valid(ivB), .in_ready(irB), .in_a(aB), .in_b(bB),
        .in_cin(cinB), .out_valid(ovB), .out_ready(orB), .out_sum(sB), .out_cout(coB));
    cpa_pipe #(.WIDTH(32), .CHUNK(32), .OUTREG("TRUE")) uC (
        .clk(clk), .rst(rstC), .in_valid(ivC), .in_ready(irC), .in_a(aC), .in_b(bC),
        .in_cin(cinC), .out_valid(ovC), .out_ready(orC), .out_sum(sC), .out_cout(coC));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [32:0] q[$];
    logic [32:0] expv;
    int          n, got, first, last, delivered, nxt;
    bit          rdy_ok, seen;

    initial begin
        rstA = 1; ivA = 0; orA = 1; aA = '0; bA = '0; cinA = 0;
        rstB = 1; ivB = 0; orB = 1; aB = '0; bB = '0; cinB = 0;
        rstC = 1; ivC = 0; orC = 1; aC = '0; bC = '0; cinC = 0;
        tick();
        tick();
        rstA = 0; rstB = 0; rstC = 0;
        #1;
        chk("rst_out_valid", ovA, 0);
        chk("rst_in_ready", irA, 1);
        chk("rst_out_sum", {coA, sA}, 0);
        chk("rst_out_valid_B", ovB, 0);

        // Full carry ripple through all four slices
        ivA = 1; aA = 32'hFFFF_FFFF; bA = 32'h0000_0001; cinA = 0;
        #1;
        chk("ripple_in_ready", irA, 1);
        tick();
        ivA = 0;
        n = 1;
        while (!ovA && n < 20) begin tick(); n++; end
        chk("ripple_latency", n, 5);
        chk("ripple_sum", sA, 32'h0);
        chk("ripple_cout", coA, 1);
        tick();
        chk("ripple_consumed", ovA, 0);

        // 100 back-to-back random items at full throughput
        q.delete(); got = 0; first = -1; last = -1; rdy_ok = 1;
        for (int c = 0; c < 120; c++) begin
            if (c < 100) begin
                ivA = 1; aA = $urandom; bA = $urandom; cinA = 1'($urandom_range(0, 1));
            end else begin
                ivA = 0;
            end
            #1;
            if (ivA && !irA) rdy_ok = 0;
            if (ivA && irA) q.push_back({1'b0, aA} + {1'b0, bA} + 33'(cinA));
            if (ovA) begin
                expv = (q.size() > 0) ? q.pop_front() : 33'h1_DEAD_BEEF;
                chk("rand_sum", {coA, sA}, expv);
                got++;
                if (first < 0) first = c;
                last = c;
            end
            tick();
        end
        chk("rand_count", got, 100);
        chk("rand_back_to_back", last - first, 99);
        chk("rand_in_ready_high", rdy_ok, 1);
        chk("rand_first_latency", first, 5);

        // Output stall: a=i, b=3i, cin=1, out_ready low in cycles 3..9
        q.delete(); delivered = 0; nxt = 1;
        for (int c = 0; c < 60 && delivered < 10; c++) begin
            ivA = (nxt <= 10); aA = 32'(nxt); bA = 32'(3 * nxt); cinA = 1;
            orA = !(c >= 3 && c <= 9);
            #1;
            if (ovA) begin
                expv = (q.size() > 0) ? q[0] : 33'h1_DEAD_BEEF;
                chk("stall_sum", {coA, sA}, expv);
                if (c == 7) chk("stall_hold_first", sA, 32'h5);
                if (!orA) chk("stall_in_ready", irA, 0);
                else begin void'(q.pop_front()); delivered++; end
            end
            if (ivA && irA) begin
                q.push_back(33'(4 * nxt + 1));
                nxt++;
            end
            tick();
        end
        orA = 1; ivA = 0;
        chk("stall_delivered", delivered, 10);
        chk("stall_accepted", nxt, 11);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ovA) seen = 1;
            tick();
        end
        chk("stall_no_duplicate", seen, 0);

        // Reset with items in flight
        ivA = 1; aA = 32'h1; bA = 32'h1; cinA = 0;
        tick();
        aA = 32'h2;
        tick();
        aA = 32'h3; rstA = 1;
        tick();
        rstA = 0; ivA = 0;
        #1;
        chk("midrst_out_valid", ovA, 0);
        chk("midrst_in_ready", irA, 1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ovA) seen = 1;
            tick();
        end
        chk("midrst_no_stale", seen, 0);
        ivA = 1; aA = 32'h1234_5678; bA = 32'h1111_1111; cinA = 0;
        tick();
        ivA = 0;
        n = 1;
        while (!ovA && n < 20) begin tick(); n++; end
        chk("midrst_new_latency", n, 5);
        chk("midrst_new_sum", {coA, sA}, 33'h0_2345_6789);

        // Narrow top slice, no output register
        ivB = 1; aB = 12'hFFF; bB = 12'hFFF; cinB = 1;
        #1;
        chk("narrow_in_ready", irB, 1);
        tick();
        ivB = 0;
        n = 1;
        while (!ovB && n < 20) begin tick(); n++; end
        chk("narrow_latency", n, 2);
        chk("narrow_sum", sB, 12'hFFF);
        chk("narrow_cout", coB, 1);

        // Single-slice degenerate case
        ivC = 1; aC = 32'h8000_0000; bC = 32'h8000_0000; cinC = 0;
        tick();
        ivC = 0;
        n = 1;
        while (!ovC && n < 20) begin tick(); n++; end
        chk("single_latency", n, 2);
        chk("single_sum", {coC, sC}, 33'h1_0000_0000);
        tick();
        chk("single_consumed", ovC, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
